// File: rtl/axil_mem_slave.sv
// rtl/axil_mem_slave.sv - AXI-Lite slave exposing a small bank of byte-writable 32-bit registers.
// Independent write and read FSMs; out-of-window accesses answer SLVERR.
module axil_mem_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int BASE_ADDR  = 0,
    parameter int NUM_WORDS  = 4
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [31:0] WIN_BYTES = 32'(4 * NUM_WORDS);
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t                w_state_q, w_state_d;
    r_state_t                r_state_q, r_state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    bvalid_q, bvalid_d;
    logic [RESP_WIDTH-1:0]   bresp_q, bresp_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [RESP_WIDTH-1:0]   rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0]   mem_d [NUM_WORDS];

    logic                    aw_fire, w_fire, ar_fire;
    logic [ADDR_WIDTH-1:0]   waddr_eff;
    logic [DATA_WIDTH-1:0]   wdata_eff;
    logic [STRB_W-1:0]       wstrb_eff;
    logic [31:0]             w_off, r_off;
    logic                    w_hit, r_hit;
    logic [IDX_W-1:0]        w_idx, r_idx;
    logic                    unused_wstrb;

    assign unused_wstrb = s_axi_wstrb[STRB_W];

    assign s_axi_awready = !s_axi_areset && (w_state_q == W_IDLE) && !aw_held_q;
    assign s_axi_wready  = !s_axi_areset && (w_state_q == W_IDLE) && !w_held_q;
    assign s_axi_arready = !s_axi_areset && (r_state_q == R_IDLE);

    assign aw_fire = s_axi_awvalid && s_axi_awready;
    assign w_fire  = s_axi_wvalid && s_axi_wready;
    assign ar_fire = s_axi_arvalid && s_axi_arready;

    // A held beat takes priority; otherwise the beat handshaking this cycle is used directly.
    assign waddr_eff = aw_held_q ? awaddr_q : s_axi_awaddr;
    assign wdata_eff = w_held_q ? wdata_q : s_axi_wdata;
    assign wstrb_eff = w_held_q ? wstrb_q : s_axi_wstrb[STRB_W-1:0];

    // Unsigned wrap makes addresses below the base fall outside the window too.
    assign w_off = 32'(waddr_eff) - 32'(BASE_ADDR);
    assign w_hit = w_off < WIN_BYTES;
    assign w_idx = w_off[IDX_W+1:2];
    assign r_off = 32'(s_axi_araddr) - 32'(BASE_ADDR);
    assign r_hit = r_off < WIN_BYTES;
    assign r_idx = r_off[IDX_W+1:2];

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_d     = mem_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axi_awaddr;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb[STRB_W-1:0];
                end
                if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
                    if (w_hit) begin
                        for (int i = 0; i < STRB_W; i++) begin
                            if (wstrb_eff[i]) begin
                                mem_d[w_idx][8*i +: 8] = wdata_eff[8*i +: 8];
                            end
                        end
                    end
                    bresp_d   = w_hit ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Reads sample mem_q, so a same-edge write to the same word returns the old value.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rdata_d   = r_hit ? mem_q[r_idx] : '0;
                    rresp_d   = r_hit ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            mem_q     <= '{default: '0};
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            mem_q     <= mem_d;
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
endmodule

// File: doc/axil_mem_slave.md
# axil_mem_slave

AXI-Lite memory-mapped slave holding a small bank of read/write 32-bit registers. It sits directly downstream of the `bus` interconnect and connects to one of its master ports (`m1_*` or `m2_*`), so it is the endpoint that answers the writes and reads the interconnect routes there. Write and read channels run independently. Byte strobes are honoured, and out-of-window addresses get an SLVERR response.

## Interface
- `DATA_WIDTH`, 32: data bus width; fixed at 32 for this block.
- `ADDR_WIDTH`, 8: byte address width; matches `bus`.
- `RESP_WIDTH`, 3: response field width; matches `bus`. OKAY=0, SLVERR=2.
- `BASE_ADDR`, 0: byte address of word 0. Must be 4-byte aligned.
- `NUM_WORDS`, 4: number of 32-bit registers, 1..64. Window is `[BASE_ADDR, BASE_ADDR+4*NUM_WORDS)`.

Ports:
- `s_axi_aclk` in 1: the single clock.
- `s_axi_areset` in 1: reset, synchronous, active-high.
- `s_axi_awaddr` in ADDR_WIDTH: write address.
- `s_axi_awvalid` in 1 / `s_axi_awready` out 1: write address handshake.
- `s_axi_wdata` in DATA_WIDTH: write data.
- `s_axi_wstrb` in DATA_WIDTH/8+1: byte enables. Bits [3:0] are used; bit 4 is ignored. The width matches `bus` master ports.
- `s_axi_wvalid` in 1 / `s_axi_wready` out 1: write data handshake.
- `s_axi_bresp` out RESP_WIDTH, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response channel.
- `s_axi_araddr` in ADDR_WIDTH, `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address channel.
- `s_axi_rdata` out DATA_WIDTH, `s_axi_rresp` out RESP_WIDTH, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data channel.

## Operation
- **Decode.**
  - `hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR+4*NUM_WORDS)`.
  - `index = (addr-BASE_ADDR)>>2`.
  - `addr[1:0]` is ignored, so misaligned addresses act as aligned.
- **Write FSM, states W_IDLE and W_RESP.**
  - In W_IDLE: `awready = !aw_held`, `wready = !w_held`.
  - An AW handshake latches the address and sets `aw_held`. A W handshake latches data and strobe and sets `w_held`. AW and W may arrive in either order or in the same cycle.
  - At the edge where AW is available (held or handshaking) and W is available (held or handshaking):
    - If hit, commit: for each i in 0..3 with `wstrb[i]` set, byte i of `mem[index]` = `wdata[8i+7:8i]`.
    - If miss, no register changes.
    - Set `bresp` to 0 (hit) or 2 (miss), set `bvalid`=1, clear both held flags, go to W_RESP.
  - In W_RESP: `awready`=`wready`=0. On `bvalid && bready`, clear `bvalid` and return to W_IDLE.
- **Read FSM, states R_IDLE and R_DATA.**
  - In R_IDLE: `arready`=1. On AR handshake:
    - `rdata = mem[index]` if hit, else 0.
    - `rresp` = 0 (hit) or 2 (miss).
    - `rvalid`=1, go to R_DATA.
  - In R_DATA: `arready`=0. `rdata`/`rresp` stay stable until `rvalid && rready`, then `rvalid`=0 and return to R_IDLE.
- **Simultaneous read and write.** A write commit and an AR handshake to the same word on the same edge return the OLD value: reads sample `mem` before that edge's write.
- **Reset.**
  - All of `mem` clears to 0.
  - Held flags, `bvalid`, `rvalid`, `bresp`, `rresp`, `rdata` reset to 0. Both FSMs go to idle.
  - `awready`, `wready`, `arready` are forced to 0 while `s_axi_areset`=1.
- **Reset mid-transaction.** Half-captured writes are discarded with no partial commit. Pending responses are dropped without a handshake.

## Timing
- Ready outputs are combinational from state and held flags only. They never depend on any `*valid` input.
- **Write latency.** `bvalid` rises in the cycle after the edge completing the later of the AW and W handshakes. Minimum sequence: AW+W same cycle N, `bvalid` in N+1. With `bready` held 1, the next write can be accepted in N+2.
- **Read latency.** AR handshake in cycle N gives `rvalid`, `rdata`, `rresp` valid in N+1. With `rready` held 1, `arready` returns in N+2. Peak rate is one read per 2 cycles.
- A written value is visible to a read whose AR handshake occurs at least one edge after the commit edge.
- Stalls are unbounded: `bvalid` and `rvalid` hold until accepted, and outputs stay stable while waiting.
- First ready is asserted in the first cycle with `s_axi_areset`=0.

## Test plan
- **Reset.** Assert reset 2 cycles, release. Required: all outputs 0 during reset. `awready`/`wready`/`arready`=1 in the first cycle after release. Read of addr 0x04 returns 0, OKAY.
- **Same-cycle write.** AW addr 0x00, W data 56, wstrb 0xF in the same cycle, `bready`=0 for 3 cycles. Required: `bvalid`=1 from the next cycle, held 3 cycles, `bresp`=0, readies 0. Readback of 0x00 = 56.
- **Out-of-order arrival.** W first (data 0xAABBCCDD, wstrb 0x5) then AW 0x08 two cycles later, over prior content 0x11223344. Required: `wready`=0 after the W handshake. `bvalid` one cycle after AW. Readback of 0x08 = 0x11BB33DD.
- **Read handshake.** AR addr 0x08 after writing 49, `rready`=0 for 2 cycles. Required: `rvalid` in the next cycle, `rdata`=49, `rresp`=0, held stable. `arready`=0 until the cycle after the R handshake.
- **Out-of-window access.** Write addr 0x10 (NUM_WORDS=4), then read 0x10. Required: `bresp`=2, no register changes (verify all 4 words), `rresp`=2, `rdata`=0.
- **Collision and mid-reset.**
  - Same-edge write 0x77 and read of addr 0x0C holding 0x66: required `rdata`=0x66, then a subsequent read returns 0x77.
  - Reset asserted after AW-only capture: required no commit, `bvalid` never rises.
